// File: rtl/scaler_h_mc.sv
// scaler_h_mc: multi-channel horizontal down-scaler with linear interpolation.
// Define SCALER_H_MC_ROUND_EN to round the interpolated result; otherwise it truncates.
module scaler_h_mc #(
    parameter int PIXEL_WIDTH   = 8,
    parameter int CHANNEL_COUNT = 3,
    parameter int PIXEL_STEP    = 128,
    parameter int COE_WIDTH     = 8,
    parameter int LINE_W_WIDTH  = 13
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [15:0]                          h_scale_step,
    input  logic [LINE_W_WIDTH-1:0]              h_size_i,
    input  logic [PIXEL_WIDTH*CHANNEL_COUNT-1:0] di_i,
    input  logic                                 de_i,
    input  logic                                 hs_i,
    input  logic                                 vs_i,
    output logic [PIXEL_WIDTH*CHANNEL_COUNT-1:0] do_o,
    output logic                                 de_o,
    output logic                                 hs_o,
    output logic                                 vs_o
);

    localparam int FRAC_W = $clog2(PIXEL_STEP);
    localparam int DW     = PIXEL_WIDTH * CHANNEL_COUNT;
    localparam int POS_W  = (((LINE_W_WIDTH + FRAC_W) > 16) ? (LINE_W_WIDTH + FRAC_W) : 16) + 1;
    localparam int IP_W   = POS_W - FRAC_W;
    localparam int WGT_W  = COE_WIDTH + 1;
    localparam int PROD_W = PIXEL_WIDTH + WGT_W;
    localparam int SUM_W  = PROD_W + 1;

    localparam logic [15:0]       STEP_MIN = 16'(PIXEL_STEP);
    localparam logic [WGT_W-1:0]  WGT_ONE  = WGT_W'(1) << COE_WIDTH;
`ifdef SCALER_H_MC_ROUND_EN
    localparam logic [SUM_W-1:0]  RND      = SUM_W'(1) << (COE_WIDTH - 1);
`else
    localparam logic [SUM_W-1:0]  RND      = '0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LINE  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [15:0]             step_q, step_d;
    logic [LINE_W_WIDTH-1:0] w_q, w_d;
    logic [LINE_W_WIDTH-1:0] n_q, n_d;
    logic [POS_W-1:0]        pos_q, pos_d;
    logic [DW-1:0]           cur_q, cur_d;

    logic                    emit;
    logic [DW-1:0]           emit_a;
    logic [DW-1:0]           emit_b;
    logic [FRAC_W-1:0]       emit_frac;
    logic [COE_WIDTH-1:0]    emit_coe;

    logic [IP_W-1:0]         ip;
    logic [FRAC_W-1:0]       frac;

    assign ip   = pos_q[POS_W-1:FRAC_W];
    assign frac = pos_q[FRAC_W-1:0];

    // Fractional position rescaled to the coefficient width.
    generate
        if (COE_WIDTH >= FRAC_W) begin : g_coe_up
            assign emit_coe = COE_WIDTH'(emit_frac) << (COE_WIDTH - FRAC_W);
        end else begin : g_coe_down
            assign emit_coe = COE_WIDTH'(emit_frac >> (FRAC_W - COE_WIDTH));
        end
    endgenerate

    // hs_i restarts the line from any state, dropping any pending flush output.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        w_d       = w_q;
        n_d       = n_q;
        pos_d     = pos_q;
        cur_d     = cur_q;
        emit      = 1'b0;
        emit_a    = cur_q;
        emit_b    = cur_q;
        emit_frac = frac;

        if (hs_i) begin
            state_d = ST_LINE;
            step_d  = (h_scale_step < STEP_MIN) ? STEP_MIN : h_scale_step;
            w_d     = h_size_i;
            n_d     = '0;
            pos_d   = '0;
        end else begin
            case (state_q)
                ST_LINE: begin
                    if (de_i) begin
                        cur_d = di_i;
                        // cur_q still holds the previous pixel, so it is the left tap.
                        if ((n_q != '0) && (ip == (IP_W'(n_q) - IP_W'(1)))) begin
                            emit   = 1'b1;
                            emit_b = di_i;
                            pos_d  = pos_q + POS_W'(step_q);
                        end
                        n_d = n_q + LINE_W_WIDTH'(1);
                        if (n_q == (w_q - LINE_W_WIDTH'(1))) begin
                            state_d = ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (ip == (IP_W'(w_q) - IP_W'(1))) begin
                        emit  = 1'b1;
                        pos_d = pos_q + POS_W'(step_q);
                    end
                    state_d = ST_IDLE;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            step_q  <= STEP_MIN;
            w_q     <= '0;
            n_q     <= '0;
            pos_q   <= '0;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            w_q     <= w_d;
            n_q     <= n_d;
            pos_q   <= pos_d;
            cur_q   <= cur_d;
        end
    end

    // Stage 1: registered emit decision with both taps and the coefficient.
    logic                 v1_q;
    logic [DW-1:0]        a1_q;
    logic [DW-1:0]        b1_q;
    logic [COE_WIDTH-1:0] c1_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            a1_q <= '0;
            b1_q <= '0;
            c1_q <= '0;
        end else begin
            v1_q <= emit;
            if (emit) begin
                a1_q <= emit_a;
                b1_q <= emit_b;
                c1_q <= emit_coe;
            end
        end
    end

    // Stage 2: full-width products, all channels sharing one coefficient.
    logic [WGT_W-1:0]  wgt_a;
    logic [WGT_W-1:0]  wgt_b;
    logic              v2_q;
    logic [PROD_W-1:0] m0_q [CHANNEL_COUNT];
    logic [PROD_W-1:0] m1_q [CHANNEL_COUNT];

    assign wgt_b = {1'b0, c1_q};
    assign wgt_a = WGT_ONE - wgt_b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2_q <= 1'b0;
            for (int k = 0; k < CHANNEL_COUNT; k++) begin
                m0_q[k] <= '0;
                m1_q[k] <= '0;
            end
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                for (int k = 0; k < CHANNEL_COUNT; k++) begin
                    m0_q[k] <= PROD_W'(a1_q[k*PIXEL_WIDTH +: PIXEL_WIDTH]) * PROD_W'(wgt_a);
                    m1_q[k] <= PROD_W'(b1_q[k*PIXEL_WIDTH +: PIXEL_WIDTH]) * PROD_W'(wgt_b);
                end
            end
        end
    end

    // Stage 3: sum, optional rounding, shift and saturate.
    logic [SUM_W-1:0] sum_c [CHANNEL_COUNT];
    logic [SUM_W-1:0] shr_c [CHANNEL_COUNT];
    logic [DW-1:0]    res_d;
    logic [DW-1:0]    do_q;
    logic             de_q;

    always_comb begin
        res_d = '0;
        for (int k = 0; k < CHANNEL_COUNT; k++) begin
            sum_c[k] = SUM_W'(m0_q[k]) + SUM_W'(m1_q[k]) + RND;
            shr_c[k] = sum_c[k] >> COE_WIDTH;
            res_d[k*PIXEL_WIDTH +: PIXEL_WIDTH] = (|shr_c[k][SUM_W-1:PIXEL_WIDTH]) ?
                {PIXEL_WIDTH{1'b1}} : shr_c[k][PIXEL_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            do_q <= '0;
            de_q <= 1'b0;
        end else begin
            de_q <= v2_q;
            if (v2_q) begin
                do_q <= res_d;
            end
        end
    end

    // Sync pipes match the three datapath stages.
    logic [2:0] hs_pipe_q;
    logic [2:0] vs_pipe_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs_pipe_q <= '0;
            vs_pipe_q <= '0;
        end else begin
            hs_pipe_q <= {hs_pipe_q[1:0], hs_i};
            vs_pipe_q <= {vs_pipe_q[1:0], vs_i};
        end
    end

    assign do_o = do_q;
    assign de_o = de_q;
    assign hs_o = hs_pipe_q[2];
    assign vs_o = vs_pipe_q[2];

endmodule

// File: tb/tb_scaler_h_mc.sv
// Bench for scaler_h_mc: directed table, abort/reset sequences and random lines vs a model.
// Input handshake: hs_i pulses once before a line, de_i marks each pixel; outputs sampled on negedge.
module tb_scaler_h_mc;
  localparam int PW = 8;
  localparam int CC = 3;
  localparam int DW = PW * CC;
  localparam int NV = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   h_scale_step = 16'd128;
  logic [12:0]   h_size_i = 13'd2;
  logic [DW-1:0] di_i = '0;
  logic          de_i = 1'b0;
  logic          hs_i = 1'b0;
  logic          vs_i = 1'b0;
  logic [DW-1:0] do_o;
  logic          de_o;
  logic          hs_o;
  logic          vs_o;

  scaler_h_mc dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .h_scale_step (h_scale_step),
    .h_size_i     (h_size_i),
    .di_i         (di_i),
    .de_i         (de_i),
    .hs_i         (hs_i),
    .vs_i         (vs_i),
    .do_o         (do_o),
    .de_o         (de_o),
    .hs_o         (hs_o),
    .vs_o         (vs_o)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // output monitor
  logic [DW-1:0] got_q[$];
  int            got_t[$];
  int            hs_t[$];
  always @(negedge clk) begin
    if (de_o) begin
      got_q.push_back(do_o);
      got_t.push_back(cyc);
    end
    if (hs_o) hs_t.push_back(cyc);
  end

  // scoreboard state
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] line_px[$];
  int            px_t[$];
  int            hs_drv;
  int            n_checks = 0;
  int            n_pass = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // driver tasks
  task automatic drive(input logic hs, input logic de, input logic [DW-1:0] d);
    @(negedge clk);
    hs_i = hs;
    de_i = de;
    di_i = d;
  endtask

  task automatic run_line(input logic [15:0] step, input int w, input int gap, input int n_send);
    px_t.delete();
    @(negedge clk);
    h_scale_step = step;
    h_size_i     = 13'(w);
    hs_i         = 1'b1;
    de_i         = 1'b0;
    hs_drv       = cyc;
    for (int i = 0; i < n_send; i++) begin
      for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, '0);
      drive(1'b0, 1'b1, line_px[i]);
      px_t.push_back(cyc);
    end
  endtask

  task automatic drain(input int n);
    repeat (n) drive(1'b0, 1'b0, '0);
  endtask

  // reference model: output k samples input coordinate k*S/PIXEL_STEP
  function automatic logic [PW-1:0] lerp(input int p0, input int p1, input int fr);
    int c;
    int v;
    logic [31:0] r;
    c = fr * 256 / 128;
    v = p0 * (256 - c) + p1 * c;
`ifdef SCALER_H_MC_ROUND_EN
    v = v + 128;
`endif
    v = v / 256;
    if (v > 255) v = 255;
    r = 32'(v);
    return r[PW-1:0];
  endfunction

  task automatic model_line(input int step, input int w);
    int s;
    s = (step < 128) ? 128 : step;
    exp_q.delete();
    for (int x = 0; x < w * 128; x += s) begin
      int ip;
      int fr;
      logic [DW-1:0] o;
      ip = x / 128;
      fr = x % 128;
      o  = '0;
      for (int k = 0; k < CC; k++) begin
        int a;
        int b;
        a = int'(line_px[ip][k*PW +: PW]);
        b = (ip + 1 < w) ? int'(line_px[ip+1][k*PW +: PW]) : a;
        o[k*PW +: PW] = lerp(a, b, fr);
      end
      exp_q.push_back(o);
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int j = 0; j < exp_q.size(); j++) begin
      if (j < got_q.size()) check($sformatf("%s_out%0d", tag, j), got_q[j], exp_q[j]);
    end
  endtask

  function automatic logic [DW-1:0] rep(input int v);
    logic [PW-1:0] p;
    p = PW'(v);
    return {CC{p}};
  endfunction

  typedef struct {
    int step;
    int w;
    int gap;
    int pix[8];
    int n_exp;
    int exp_v[8];
  } vec_t;

  vec_t vecs[NV];
  int   base;

  initial begin
    vecs[0] = '{256, 8, 0, '{1, 2, 3, 4, 5, 6, 7, 8}, 4, '{1, 3, 5, 7, 0, 0, 0, 0}};
    vecs[1] = '{192, 6, 0, '{10, 20, 30, 40, 50, 60, 0, 0}, 4, '{10, 25, 40, 55, 0, 0, 0, 0}};
    vecs[2] = '{256, 7, 0, '{1, 2, 3, 4, 5, 6, 7, 0}, 4, '{1, 3, 5, 7, 0, 0, 0, 0}};
`ifdef SCALER_H_MC_ROUND_EN
    vecs[3] = '{192, 6, 0, '{0, 1, 0, 1, 0, 1, 0, 0}, 4, '{0, 1, 1, 1, 0, 0, 0, 0}};
`else
    vecs[3] = '{192, 6, 0, '{0, 1, 0, 1, 0, 1, 0, 0}, 4, '{0, 0, 1, 0, 0, 0, 0, 0}};
`endif
    vecs[4] = '{64, 5, 0, '{1, 2, 3, 4, 5, 0, 0, 0}, 5, '{1, 2, 3, 4, 5, 0, 0, 0}};
    vecs[5] = '{64, 5, 3, '{1, 2, 3, 4, 5, 0, 0, 0}, 5, '{1, 2, 3, 4, 5, 0, 0, 0}};
    vecs[6] = '{128, 2, 0, '{100, 200, 0, 0, 0, 0, 0, 0}, 2, '{100, 200, 0, 0, 0, 0, 0, 0}};
    vecs[7] = '{384, 8, 1, '{0, 30, 60, 90, 120, 150, 180, 210}, 3, '{0, 90, 180, 0, 0, 0, 0, 0}};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_do", do_o, 0);
    check("rst_de", de_o, 0);
    check("rst_hs", hs_o, 0);
    check("rst_vs", vs_o, 0);
    rst_n = 1'b1;
    drain(3);

    // directed table
    for (int i = 0; i < NV; i++) begin
      line_px.delete();
      for (int j = 0; j < vecs[i].w; j++) line_px.push_back(rep(vecs[i].pix[j]));
      got_q.delete();
      got_t.delete();
      hs_t.delete();
      run_line(16'(vecs[i].step), vecs[i].w, vecs[i].gap, vecs[i].w);
      drain(8);
      check($sformatf("vec%0d_count", i), got_q.size(), vecs[i].n_exp);
      for (int j = 0; j < vecs[i].n_exp; j++) begin
        if (j < got_q.size()) check($sformatf("vec%0d_out%0d", i, j), got_q[j], rep(vecs[i].exp_v[j]));
      end
      if (i == 0 && got_t.size() > 0) check("first_de_latency", got_t[0] - px_t[1], 3);
      if (i == 0 && hs_t.size() > 0) check("hs_latency", hs_t[0] - hs_drv, 3);
      if (i == 2 && got_t.size() > 3) check("flush_latency", got_t[3] - px_t[6], 4);
    end

    // hs_i mid-line restarts without flush
    got_q.delete();
    line_px.delete();
    for (int j = 0; j < 8; j++) line_px.push_back(rep(j + 1));
    run_line(16'd256, 8, 0, 3);
    line_px.delete();
    for (int j = 0; j < 4; j++) line_px.push_back(rep(j + 11));
    run_line(16'd256, 4, 0, 4);
    drain(8);
    check("abort_line_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check("abort_line_out0", got_q[0], rep(1));
      check("abort_line_out1", got_q[1], rep(11));
      check("abort_line_out2", got_q[2], rep(13));
    end

    // hs_i during FLUSH drops the pending flush output
    got_q.delete();
    line_px.delete();
    line_px.push_back(rep(50));
    line_px.push_back(rep(60));
    line_px.push_back(rep(70));
    run_line(16'd128, 3, 0, 3);
    line_px.delete();
    line_px.push_back(rep(5));
    line_px.push_back(rep(6));
    run_line(16'd128, 2, 0, 2);
    drain(8);
    check("abort_flush_count", got_q.size(), 4);
    if (got_q.size() == 4) begin
      check("abort_flush_out1", got_q[1], rep(60));
      check("abort_flush_out2", got_q[2], rep(5));
    end

    // vs pipeline, then reset mid-line
    vs_i = 1'b1;
    drain(4);
    check("vs_follow", vs_o, 1);
    line_px.delete();
    for (int j = 0; j < 8; j++) line_px.push_back(rep(j + 1));
    run_line(16'd128, 8, 0, 3);
    @(negedge clk);
    rst_n = 1'b0;
    de_i  = 1'b1;
    di_i  = rep(4);
    @(negedge clk);
    check("midrst_do", do_o, 0);
    check("midrst_de", de_o, 0);
    check("midrst_hs", hs_o, 0);
    check("midrst_vs", vs_o, 0);
    rst_n = 1'b1;
    vs_i  = 1'b0;
    #1 base = got_q.size();
    for (int j = 0; j < 6; j++) drive(1'b0, 1'b1, rep(j + 5));
    drain(6);
    check("midrst_no_de", got_q.size(), base);

    got_q.delete();
    line_px.delete();
    for (int j = 0; j < 5; j++) line_px.push_back(rep(j + 1));
    model_line(128, 5);
    run_line(16'd128, 5, 0, 5);
    drain(8);
    compare_model("post_rst");

    // random lines against the model
    for (int r = 0; r < 10; r++) begin
      int step;
      int w;
      int gap;
      step = int'($urandom_range(100, 640));
      w    = int'($urandom_range(2, 20));
      gap  = int'($urandom_range(0, 2));
      line_px.delete();
      for (int j = 0; j < w; j++) line_px.push_back(DW'($urandom));
      model_line(step, w);
      got_q.delete();
      run_line(16'(step), w, gap, w);
      drain(8);
      compare_model($sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: cycle %0d reached without finishing", cyc);
    $fatal(1);
  end
endmodule
